div_req_ctrl: RTL and testbench
===============================

Name: div_req_ctrl

Overview:
- Requester side of the divider handshake: takes one divide/remainder micro-op from issue, drives div_unit's request/operand/kill inputs, and waits out its stall.
- Captures the quotient or remainder, formats 32-bit results, and presents a single-entry writeback with valid/ready.
- Sits between the issue queue and div_unit inside the execution stage.
- Only one operation is in flight at a time.

Parameters:
TAG_WIDTH, 5, width of the ROB/destination tag carried with the op
LAT_WIDTH, 7, width of the latency counter (saturates at all-ones)

Ports:
clk_i  in  1  single clock
rst_i  in  1  asynchronous reset, active-high
flush_i  in  1  pipeline flush; kills any in-flight op
valid_i  in  1  issue offers a divide op
ready_o  out  1  block can accept an op this cycle
int_32_i  in  1  W-variant (32-bit) op
signed_op_i  in  1  signed divide
rem_i  in  1  1 = return remainder, 0 = quotient
dvnd_i  in  64  dividend
dvsr_i  in  64  divisor
tag_i  in  TAG_WIDTH  op tag
div_request_o  out  1  request to div_unit
div_kill_o  out  1  kill to div_unit
div_int_32_o  out  1  registered int_32
div_signed_op_o  out  1  registered signed flag
div_dvnd_o  out  64  registered dividend
div_dvsr_o  out  64  registered divisor
div_quo_i  in  64  div_unit quotient
div_rmd_i  in  64  div_unit remainder
div_stall_i  in  1  div_unit busy
wb_valid_o  out  1  result valid
wb_ready_i  in  1  writeback accepts result
wb_data_o  out  64  result
wb_tag_o  out  TAG_WIDTH  result tag
lat_o  out  LAT_WIDTH  WAIT-cycle count of last completed op

Behaviour:
- Reset values: state IDLE; all outputs 0; operand, tag and data registers 0; lat_o 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - ready_o = !flush_i.
  - valid_i && ready_o registers the operands, flags, rem_i and tag, then moves to REQ.
- REQ:
  - div_request_o = 1 for exactly one cycle; move to WAIT.
  - Clear the latency counter.
- WAIT:
  - Increment the latency counter every cycle (saturating).
  - On the first cycle with div_stall_i == 0, capture the result, set lat_o, and move to RESP. The earliest completion is the cycle after REQ.
- Result formatting:
  - Select div_rmd_i if rem, otherwise div_quo_i.
  - If int_32, wb_data_o = {32{sel[31]}, sel[31:0]}; otherwise sel.
- RESP:
  - wb_valid_o = 1; data and tag stay stable until wb_ready_i.
  - wb_valid_o && wb_ready_i moves to IDLE. There is no back-to-back accept in the same cycle: ready_o is 1 only in IDLE.
- Flush:
  - In REQ or WAIT: div_kill_o = 1 combinationally that cycle, div_request_o is forced to 0, and the next state is IDLE. lat_o is not updated.
  - In RESP: wb_valid_o is forced to 0 that cycle and the next state is IDLE.
  - In IDLE: no op is accepted.
- A flush and a stall deassert in the same WAIT cycle: the flush wins and the result is discarded.
- div_kill_o is never asserted outside REQ/WAIT.
- Asynchronous reset mid-op returns to IDLE immediately and drops the op; no kill pulse is generated. The same rst_i is assumed to reset div_unit.

Optional Feature:
DIV_ZERO_BYPASS_EN
- Defined: in IDLE, accepting an op whose divisor is zero (dvsr_i == 0, or dvsr_i[31:0] == 0 when int_32) goes directly to RESP without asserting div_request_o.
  - Result follows RISC-V: quotient = all-ones; remainder = dividend.
  - Both use the 32-bit sign-extension rule when int_32.
  - lat_o is set to 0.
- Undefined: every op goes through div_unit.

Test Plan:
- dvnd=100, dvsr=7, rem=0; div_unit stall for 3 cycles, then quo=14 -> exactly one request pulse; wb_data=14 with the tag; lat_o=4 (the WAIT cycles, including the completion cycle).
- dvnd=100, dvsr=7, rem=1, int_32=1; div_unit returns rmd=0x00000000_80000002 -> wb_data=0xFFFFFFFF_80000002.
- flush_i pulsed on the 2nd WAIT cycle -> div_kill_o=1 that cycle; no wb_valid_o; ready_o=1 on the next cycle.
- RESP held with wb_ready_i=0 for 5 cycles -> wb_data/tag stable; ready_o=0 throughout; IDLE after the handshake.
- rst_i asserted in WAIT -> all outputs 0 asynchronously; a new op is accepted after release.
- With DIV_ZERO_BYPASS_EN, dvnd=0x1234, dvsr=0, rem=0 -> no div_request_o; wb_data=0xFFFFFFFF_FFFFFFFF on the cycle after accept. With rem=1 -> wb_data=0x1234.

Source files
------------

// File: rtl/div_req_ctrl_if.sv
// Request/response channel between div_req_ctrl (master) and div_unit (slave).
interface div_req_ctrl_if;
  logic        div_request;
  logic        div_kill;
  logic        div_int_32;
  logic        div_signed_op;
  logic [63:0] div_dvnd;
  logic [63:0] div_dvsr;
  logic [63:0] div_quo;
  logic [63:0] div_rmd;
  logic        div_stall;

  modport master (
    output div_request, div_kill, div_int_32, div_signed_op, div_dvnd, div_dvsr,
    input  div_quo, div_rmd, div_stall
  );

  modport slave (
    input  div_request, div_kill, div_int_32, div_signed_op, div_dvnd, div_dvsr,
    output div_quo, div_rmd, div_stall
  );
endinterface

// File: rtl/div_req_ctrl.sv
// Single-op divider requester: issue -> div_unit handshake -> formatted writeback.
// Optional macro DIV_ZERO_BYPASS_EN: zero-divisor ops skip div_unit and answer per RISC-V.
module div_req_ctrl #(
  parameter int unsigned TAG_WIDTH = 5,
  parameter int unsigned LAT_WIDTH = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 int_32_i,
  input  logic                 signed_op_i,
  input  logic                 rem_i,
  input  logic [63:0]          dvnd_i,
  input  logic [63:0]          dvsr_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  div_req_ctrl_if.master       div,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [63:0]          wb_data_o,
  output logic [TAG_WIDTH-1:0] wb_tag_o,
  output logic [LAT_WIDTH-1:0] lat_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic                 accept, complete, bypass;
  logic                 rem_q, int_32_q, signed_op_q;
  logic [63:0]          dvnd_q, dvsr_q, data_q;
  logic [63:0]          sel, fmt_data, bypass_data;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [LAT_WIDTH-1:0] lat_cnt_q, lat_q, lat_inc;

  function automatic logic [63:0] fmt(input logic is_32, input logic [63:0] v);
    return is_32 ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  assign sel      = rem_q ? div.div_rmd : div.div_quo;
  assign fmt_data = fmt(int_32_q, sel);
  assign lat_inc  = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + LAT_WIDTH'(1);

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass      = int_32_i ? (dvsr_i[31:0] == '0) : (dvsr_i == '0);
  assign bypass_data = fmt(int_32_i, rem_i ? dvnd_i : '1);
`else
  assign bypass      = 1'b0;
  assign bypass_data = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    ready_o         = 1'b0;
    div.div_request = 1'b0;
    div.div_kill    = 1'b0;
    wb_valid_o      = 1'b0;
    accept          = 1'b0;
    complete        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // held low while reset is asserted so every output reads 0 in reset
        ready_o = !flush_i && !rst_i;
        if (valid_i && ready_o) begin
          accept  = 1'b1;
          state_d = bypass ? RESP : REQ;
        end
      end
      REQ: begin
        if (flush_i) begin
          div.div_kill = 1'b1;
          state_d      = IDLE;
        end else begin
          div.div_request = 1'b1;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (flush_i) begin
          div.div_kill = 1'b1;
          state_d      = IDLE;
        end else if (!div.div_stall) begin
          complete = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          wb_valid_o = 1'b1;
          if (wb_ready_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q       <= 1'b0;
      int_32_q    <= 1'b0;
      signed_op_q <= 1'b0;
      dvnd_q      <= '0;
      dvsr_q      <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      lat_cnt_q   <= '0;
      lat_q       <= '0;
    end else begin
      if (accept) begin
        rem_q       <= rem_i;
        int_32_q    <= int_32_i;
        signed_op_q <= signed_op_i;
        dvnd_q      <= dvnd_i;
        dvsr_q      <= dvsr_i;
        tag_q       <= tag_i;
        if (bypass) begin
          data_q <= bypass_data;
          lat_q  <= '0;
        end
      end
      if (state_q == REQ)  lat_cnt_q <= '0;
      if (state_q == WAIT) lat_cnt_q <= lat_inc;
      // lat_inc already counts the completing WAIT cycle
      if (complete) begin
        data_q <= fmt_data;
        lat_q  <= lat_inc;
      end
    end
  end

  assign div.div_int_32    = int_32_q;
  assign div.div_signed_op = signed_op_q;
  assign div.div_dvnd      = dvnd_q;
  assign div.div_dvsr      = dvsr_q;
  assign wb_data_o         = data_q;
  assign wb_tag_o          = tag_q;
  assign lat_o             = lat_q;

endmodule

// File: tb/tb_div_req_ctrl.sv
// Randomised self-checking bench for div_req_ctrl; the bench plays div_unit and writeback.
module tb_div_req_ctrl;
  localparam int unsigned TW = 5;
  localparam int unsigned LW = 7;

  logic          clk = 1'b0;
  logic          rst, flush, valid, int32, sgn, rem, wb_ready;
  logic [63:0]   dvnd, dvsr;
  logic [TW-1:0] tag;
  logic          ready, wb_valid;
  logic [63:0]   wb_data;
  logic [TW-1:0] wb_tag;
  logic [LW-1:0] lat;
  logic [LW-1:0] exp_lat;
  int            total = 0, bad = 0, req_cnt = 0, kill_cnt = 0;

  div_req_ctrl_if dif();

  div_req_ctrl #(.TAG_WIDTH(TW), .LAT_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ready),
    .int_32_i(int32), .signed_op_i(sgn), .rem_i(rem), .dvnd_i(dvnd), .dvsr_i(dvsr),
    .tag_i(tag), .div(dif), .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_data_o(wb_data), .wb_tag_o(wb_tag), .lat_o(lat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dif.div_request === 1'b1) req_cnt++;
    if (dif.div_kill === 1'b1) kill_cnt++;
  end

  // Reference: result is the selected word, sign-extended from bit 31 for W ops.
  function automatic logic [63:0] model_result(input logic i32, input logic r,
                                               input logic [63:0] q, input logic [63:0] m);
    logic [63:0] v;
    int          w;
    v = r ? m : q;
    if (!i32) return v;
    w = int'(v[31:0]);
    return 64'(longint'(w));
  endfunction

  function automatic logic [LW-1:0] model_lat(input int stalls);
    int n;
    n = stalls + 1;
    if (n > (1 << LW) - 1) n = (1 << LW) - 1;
    return LW'(n);
  endfunction

  task automatic issue(input logic i32, input logic s, input logic r,
                       input logic [63:0] a, input logic [63:0] b, input logic [TW-1:0] t);
    @(negedge clk);
    valid = 1'b1; int32 = i32; sgn = s; rem = r; dvnd = a; dvsr = b; tag = t;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 0; valid = 0; int32 = 0; sgn = 0; rem = 0; wb_ready = 0;
    dvnd = '0; dvsr = '0; tag = '0;
    dif.div_quo = '0; dif.div_rmd = '0; dif.div_stall = 1'b0;
    exp_lat = '0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({ready, wb_valid, dif.div_request, dif.div_kill, dif.div_int_32, dif.div_signed_op,
         dif.div_dvnd, dif.div_dvsr, wb_data, wb_tag, lat} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got ready=%b wbv=%b req=%b kill=%b data=%h tag=%h lat=%0d required all 0",
               ready, wb_valid, dif.div_request, dif.div_kill, wb_data, wb_tag, lat);
    end
    @(negedge clk); rst = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_idle_ready got=%b required=1", ready); end
  endtask

  task automatic test_quotient;
    int base;
    base = req_cnt;
    @(negedge clk);
    valid = 1; int32 = 0; sgn = 1; rem = 0; dvnd = 64'd100; dvsr = 64'd7; tag = 5'h0b;
    dif.div_quo = 64'd14; dif.div_rmd = 64'd2;
    #1;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL quo_accept_ready got=%b required=1", ready); end
    @(negedge clk); valid = 0; dif.div_stall = 1'b1;
    #1;
    total++;
    if ({dif.div_request, dif.div_signed_op, dif.div_dvnd, dif.div_dvsr} !== {2'b11, 64'd100, 64'd7}) begin
      bad++;
      $display("FAIL quo_req got req=%b sgn=%b dvnd=%0d dvsr=%0d required 1 1 100 7",
               dif.div_request, dif.div_signed_op, dif.div_dvnd, dif.div_dvsr);
    end
    repeat (4) @(negedge clk);
    dif.div_stall = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({wb_valid, wb_data, wb_tag, lat} !== {1'b1, 64'd14, 5'h0b, 7'd4} || req_cnt - base != 1) begin
      bad++;
      $display("FAIL quo_result got v=%b data=%0d tag=%h lat=%0d reqs=%0d required 1 14 0b 4 1",
               wb_valid, wb_data, wb_tag, lat, req_cnt - base);
    end
    exp_lat = 7'd4;
    wb_ready = 1; @(negedge clk); wb_ready = 0; #1;
    total++;
    if ({ready, wb_valid} !== 2'b10) begin
      bad++; $display("FAIL quo_handshake got ready=%b wbv=%b required 1 0", ready, wb_valid);
    end
  endtask

  task automatic test_rem_int32;
    dif.div_stall = 1'b0;
    dif.div_quo = 64'd14; dif.div_rmd = 64'h0000_0000_8000_0002;
    issue(1, 1, 1, 64'd100, 64'd7, 5'h13);
    repeat (2) @(negedge clk); #1;
    total++;
    if ({wb_valid, wb_data, wb_tag, lat, dif.div_int_32} !== {1'b1, 64'hFFFF_FFFF_8000_0002, 5'h13, 7'd1, 1'b1}) begin
      bad++;
      $display("FAIL rem_int32 got v=%b data=%h tag=%h lat=%0d i32=%b required 1 ffffffff80000002 13 1 1",
               wb_valid, wb_data, wb_tag, lat, dif.div_int_32);
    end
    exp_lat = 7'd1;
    wb_ready = 1; @(negedge clk); wb_ready = 0;
  endtask

  task automatic test_flush;
    int kbase, rbase;
    kbase = kill_cnt;
    issue(0, 0, 0, 64'd50, 64'd5, 5'h04);
    dif.div_stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush = 1; dif.div_stall = 1'b0;
    #1;
    total++;
    if ({dif.div_kill, dif.div_request, wb_valid} !== 3'b100) begin
      bad++; $display("FAIL flush_wait_kill got kill=%b req=%b wbv=%b required 1 0 0",
                      dif.div_kill, dif.div_request, wb_valid);
    end
    @(negedge clk); flush = 0; #1;
    total++;
    if ({ready, wb_valid, dif.div_kill, lat} !== {3'b100, exp_lat} || kill_cnt - kbase != 1) begin
      bad++; $display("FAIL flush_wait_after got ready=%b wbv=%b kill=%b lat=%0d kills=%0d required 1 0 0 %0d 1",
                      ready, wb_valid, dif.div_kill, lat, kill_cnt - kbase, exp_lat);
    end
    // flush while the result is waiting in writeback
    issue(0, 0, 1, 64'd9, 64'd4, 5'h05);
    dif.div_rmd = 64'd1;
    repeat (2) @(negedge clk);
    kbase = kill_cnt;
    flush = 1; #1;
    total++;
    if ({wb_valid, dif.div_kill} !== 2'b00) begin
      bad++; $display("FAIL flush_resp got wbv=%b kill=%b required 0 0", wb_valid, dif.div_kill);
    end
    exp_lat = 7'd1;
    @(negedge clk); flush = 0; #1;
    total++;
    if ({ready, wb_valid} !== 2'b10 || kill_cnt != kbase) begin
      bad++; $display("FAIL flush_resp_after got ready=%b wbv=%b kills=%0d required 1 0 0", ready, wb_valid, kill_cnt - kbase);
    end
    // flush in IDLE blocks acceptance
    rbase = req_cnt;
    @(negedge clk); valid = 1; flush = 1; #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL flush_idle_ready got=%b required 0", ready); end
    @(negedge clk); valid = 0; flush = 0;
    @(negedge clk); #1;
    total++;
    if (req_cnt != rbase || ready !== 1'b1) begin
      bad++; $display("FAIL flush_idle_noaccept got reqs=%0d ready=%b required 0 1", req_cnt - rbase, ready);
    end
  endtask

  task automatic test_resp_hold;
    issue(0, 0, 0, 64'd77, 64'd3, 5'h1e);
    dif.div_quo = 64'h0123_4567_89ab_cdef;
    repeat (2) @(negedge clk);
    exp_lat = 7'd1;
    for (int c = 0; c < 5; c++) begin
      dif.div_quo = {$urandom, $urandom}; dif.div_rmd = {$urandom, $urandom};
      #1;
      total++;
      if ({wb_valid, ready, wb_data, wb_tag} !== {2'b10, 64'h0123_4567_89ab_cdef, 5'h1e}) begin
        bad++; $display("FAIL resp_hold cycle=%0d got v=%b ready=%b data=%h tag=%h required 1 0 0123456789abcdef 1e",
                        c, wb_valid, ready, wb_data, wb_tag);
      end
      @(negedge clk);
    end
    wb_ready = 1; @(negedge clk); wb_ready = 0; #1;
    total++;
    if ({ready, wb_valid} !== 2'b10) begin
      bad++; $display("FAIL resp_release got ready=%b wbv=%b required 1 0", ready, wb_valid);
    end
  endtask

  task automatic test_async_reset;
    int kbase;
    kbase = kill_cnt;
    issue(1, 1, 0, 64'd1000, 64'd10, 5'h07);
    dif.div_stall = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ready, wb_valid, dif.div_request, dif.div_kill, dif.div_int_32, dif.div_signed_op,
         dif.div_dvnd, dif.div_dvsr, wb_data, wb_tag, lat} !== '0 || kill_cnt != kbase) begin
      bad++;
      $display("FAIL async_reset got ready=%b wbv=%b req=%b kill=%b i32=%b dvnd=%h data=%h lat=%0d kills=%0d required all 0",
               ready, wb_valid, dif.div_request, dif.div_kill, dif.div_int_32, dif.div_dvnd, wb_data, lat, kill_cnt - kbase);
    end
    @(negedge clk); rst = 1'b0; dif.div_stall = 1'b0;
    dif.div_quo = 64'd55;
    issue(0, 0, 0, 64'd110, 64'd2, 5'h08);
    repeat (2) @(negedge clk); #1;
    total++;
    if ({wb_valid, wb_data, wb_tag, lat} !== {1'b1, 64'd55, 5'h08, 7'd1}) begin
      bad++; $display("FAIL after_reset_op got v=%b data=%0d tag=%h lat=%0d required 1 55 08 1",
                      wb_valid, wb_data, wb_tag, lat);
    end
    exp_lat = 7'd1;
    wb_ready = 1; @(negedge clk); wb_ready = 0;
  endtask

  task automatic test_random;
    logic          i32, s, r, fl, flushed;
    logic [63:0]   a, b, q, m, exp_d;
    logic [TW-1:0] t;
    int            k, j, w, base, kbase;
    for (int n = 0; n < 40; n++) begin
      i32 = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom}; b = {$urandom, $urandom} | 64'h1;
      q = {$urandom, $urandom}; m = {$urandom, $urandom}; t = TW'($urandom);
      k = (n == 20) ? 130 : int'($urandom_range(0, 5));
      fl = (n == 5) || ($urandom_range(0, 4) == 0);
      j = (n == 5) ? k : int'($urandom_range(0, k));
      base = req_cnt; kbase = kill_cnt;
      issue(i32, s, r, a, b, t);
      dvnd = {$urandom, $urandom}; dvsr = {$urandom, $urandom};
      dif.div_quo = q; dif.div_rmd = m; dif.div_stall = 1'b1;
      #1;
      total++;
      if ({dif.div_request, dif.div_int_32, dif.div_signed_op, dif.div_dvnd, dif.div_dvsr} !== {1'b1, i32, s, a, b}) begin
        bad++; $display("FAIL rnd_req op=%0d got req=%b i32=%b sgn=%b dvnd=%h dvsr=%h required 1 %b %b %h %h",
                        n, dif.div_request, dif.div_int_32, dif.div_signed_op, dif.div_dvnd, dif.div_dvsr, i32, s, a, b);
      end
      flushed = 1'b0;
      for (int c = 0; c <= k && !flushed; c++) begin
        @(negedge clk);
        dif.div_stall = (c < k);
        if (fl && c == j) begin
          flush = 1'b1; flushed = 1'b1;
          #1;
          total++;
          if ({dif.div_kill, dif.div_request} !== 2'b10) begin
            bad++; $display("FAIL rnd_kill op=%0d got kill=%b req=%b required 1 0", n, dif.div_kill, dif.div_request);
          end
        end
      end
      @(negedge clk); flush = 1'b0; #1;
      total++;
      if (flushed) begin
        if ({ready, wb_valid, lat} !== {2'b10, exp_lat} || kill_cnt - kbase != 1) begin
          bad++; $display("FAIL rnd_flushed op=%0d got ready=%b wbv=%b lat=%0d kills=%0d required 1 0 %0d 1",
                          n, ready, wb_valid, lat, kill_cnt - kbase, exp_lat);
        end
      end else begin
        exp_d = model_result(i32, r, q, m);
        exp_lat = model_lat(k);
        if ({wb_valid, wb_data, wb_tag, lat} !== {1'b1, exp_d, t, exp_lat} || req_cnt - base != 1 || kill_cnt != kbase) begin
          bad++; $display("FAIL rnd_result op=%0d got v=%b data=%h tag=%h lat=%0d reqs=%0d required 1 %h %h %0d 1",
                          n, wb_valid, wb_data, wb_tag, lat, req_cnt - base, exp_d, t, exp_lat);
        end
        w = int'($urandom_range(0, 3));
        repeat (w) @(negedge clk);
        wb_ready = 1; @(negedge clk); wb_ready = 0; #1;
        total++;
        if ({ready, wb_valid} !== 2'b10) begin
          bad++; $display("FAIL rnd_release op=%0d got ready=%b wbv=%b required 1 0", n, ready, wb_valid);
        end
      end
    end
  endtask

`ifdef DIV_ZERO_BYPASS_EN
  task automatic test_zero_divisor;
    int base;
    logic [63:0] exp_v [3];
    logic [2:0]  rr, ii;
    exp_v[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_v[1] = 64'h0000_0000_0000_1234;
    exp_v[2] = 64'hFFFF_FFFF_8000_0000;
    rr = 3'b110; ii = 3'b100;
    for (int n = 0; n < 3; n++) begin
      base = req_cnt;
      if (n < 2) issue(ii[n], 1'b1, rr[n], 64'h1234, 64'h0, 5'h10);
      else       issue(ii[n], 1'b1, rr[n], 64'h5555_0000_8000_0000, 64'h1_0000_0000, 5'h10);
      #1;
      total++;
      if ({wb_valid, wb_data, lat} !== {1'b1, exp_v[n], 7'd0} || req_cnt != base) begin
        bad++; $display("FAIL zero_bypass case=%0d got v=%b data=%h lat=%0d reqs=%0d required 1 %h 0 0",
                        n, wb_valid, wb_data, lat, req_cnt - base, exp_v[n]);
      end
      wb_ready = 1; @(negedge clk); wb_ready = 0;
    end
    exp_lat = '0;
  endtask
`else
  task automatic test_zero_divisor;
    int base;
    base = req_cnt;
    dif.div_stall = 1'b0; dif.div_quo = 64'hFFFF_FFFF_FFFF_FFFF;
    issue(0, 0, 0, 64'h1234, 64'h0, 5'h10);
    #1;
    total++;
    if ({dif.div_request, wb_valid} !== 2'b10) begin
      bad++; $display("FAIL zero_via_unit_req got req=%b wbv=%b required 1 0", dif.div_request, wb_valid);
    end
    repeat (2) @(negedge clk); #1;
    total++;
    if ({wb_valid, wb_data, lat} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 7'd1} || req_cnt - base != 1) begin
      bad++; $display("FAIL zero_via_unit got v=%b data=%h lat=%0d reqs=%0d required 1 ffffffffffffffff 1 1",
                      wb_valid, wb_data, lat, req_cnt - base);
    end
    exp_lat = 7'd1;
    wb_ready = 1; @(negedge clk); wb_ready = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_quotient;
    test_rem_int32;
    test_flush;
    test_resp_hold;
    test_async_reset;
    test_random;
    test_zero_divisor;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
